mlp_dot_seq: RTL and testbench
==============================

MLP_DOT_SEQ -- requirements
Module: mlp_dot_seq

Interface
REQ-001 SHALL have parameter A_WIDTH, default 16, signed operand A width.
REQ-002 SHALL have parameter B_WIDTH, default 16, signed operand B width.
REQ-003 SHALL have parameter ACC_WIDTH, default 64, accumulator/result width; ACC_WIDTH >= A_WIDTH+B_WIDTH.
REQ-004 SHALL have parameter MAX_LEN, default 256, maximum vector length; LEN_W = $clog2(MAX_LEN+1), ADDR_W = $clog2(MAX_LEN).
REQ-005 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_len  in  LEN_W  vector length, 0..MAX_LEN
- rd_en  out  1  operand read strobe
- rd_addr  out  ADDR_W  operand index
- rd_a  in  A_WIDTH  signed operand, valid 1 cycle after rd_en
- rd_b  in  B_WIDTH  signed operand, valid 1 cycle after rd_en
- res_valid  out  1  result offered
- res_ready  in  1  result consumed when both high
- res_data  out  ACC_WIDTH  signed dot-product result
- busy  out  1  high in every state except IDLE

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, DRAIN, OUT.
REQ-007 cmd_ready SHALL be 1 only in IDLE; cmd_len is sampled on the handshake cycle (cycle 0).
REQ-008 IDLE->FETCH on handshake with cmd_len>0; IDLE->OUT with res_data=0 and no rd_en on handshake with cmd_len=0.
REQ-009 In FETCH, rd_en SHALL be 1 and rd_addr SHALL be k in cycle k+1, for k = 0..len-1, with no gaps.
REQ-010 The operand pair returned in cycle k+2 SHALL drive the MAC: start for k=0, valid for k>0, never both.
REQ-011 FETCH->DRAIN after issuing address len-1; DRAIN lasts exactly one cycle (last product accumulates); DRAIN->OUT.
REQ-012 res_valid SHALL first assert in cycle len+2 and hold with res_data stable until res_ready; OUT->IDLE on the res_valid&&res_ready cycle.
REQ-013 cmd_ready SHALL NOT be asserted in the cycle OUT completes; the next command is accepted at the earliest one cycle later.
REQ-014 Accumulation SHALL be full-precision signed: product sign-extended to ACC_WIDTH, two's-complement wrap on overflow, no saturation.
REQ-015 cmd_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-016 rd_en SHALL be 0 outside FETCH; rd_addr SHALL hold its last value when rd_en=0.

Reset
REQ-017 While rst_n=0 at a clock edge: state IDLE, cmd_ready=1 after release, rd_en=0, rd_addr=0, res_valid=0, res_data=0, busy=0, counters 0.
REQ-018 Reset mid-operation SHALL abort immediately; no res_valid from the aborted command; MAC strobes forced 0 in the reset cycle.

Configuration
REQ-019 With macro MLP_DOT_SEQ_RELU_EN defined, res_data SHALL be max(0, acc); negative accumulations output 0.
REQ-020 Without MLP_DOT_SEQ_RELU_EN, res_data SHALL equal the raw accumulator value.

Structure
REQ-021 FSM state encoding and a LEN_W/ADDR_W width helper SHALL live in shared package mlp_pkg.
REQ-022 The block SHALL instantiate one sub-module, MLP_mac, for the multiply-accumulate datapath; no other sub-modules.

Verification
REQ-023 len=3, a={1,2,3}, b={4,5,6} -> rd_en cycles 1-3, res_valid at cycle 5, res_data=32.
REQ-024 len=2, a={-3,1}, b={7,2} -> res_data=-19; with MLP_DOT_SEQ_RELU_EN -> 0.
REQ-025 len=0 -> no rd_en, res_valid at cycle 1, res_data=0.
REQ-026 res_ready held low 10 cycles after res_valid -> res_data stable, cmd_ready=0 throughout, IDLE one cycle after acceptance.
REQ-027 rst_n low at cycle 3 of a len=8 command -> no res_valid; next len=1 command a=-32768, b=-32768 -> res_data=1073741824.
REQ-028 len=MAX_LEN with all operands 32767 -> rd_addr sweeps 0..255 gap-free, res_data=256*32767^2.

Source files
------------

// File: rtl/mlp_pkg.sv
// mlp_pkg -- shared definitions for the mlp_dot_seq dot-product sequencer.
//   state_t      : FSM state encoding (IDLE, FETCH, DRAIN, OUT)
//   calc_len_w   : width of a length field able to hold 0..max_len
//   calc_addr_w  : width of an operand index 0..max_len-1 (at least 1 bit)
package mlp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int calc_addr_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/mlp_mac.sv
// MLP_mac -- signed multiply-accumulate datapath.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset (clears accumulator)
//   i_clr             : clear accumulator to 0
//   i_start           : load accumulator with the current product
//   i_valid           : add the current product to the accumulator
//   i_a, i_b          : signed operands
//   o_acc             : signed accumulator (two's-complement wrap, no saturation)
module MLP_mac #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clr,
  input  logic                        i_start,
  input  logic                        i_valid,
  input  logic signed [A_WIDTH-1:0]   i_a,
  input  logic signed [B_WIDTH-1:0]   i_b,
  output logic signed [ACC_WIDTH-1:0] o_acc
);

  logic signed [A_WIDTH+B_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]       w_prod_ext;
  logic signed [ACC_WIDTH-1:0]       r_acc;

  assign w_prod     = i_a * i_b;
  // Size cast of a signed value sign-extends the full-precision product.
  assign w_prod_ext = ACC_WIDTH'(w_prod);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_start) begin
      r_acc <= w_prod_ext;
    end else if (i_valid) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mlp_dot_seq.sv
// mlp_dot_seq -- sequential signed dot-product engine.
// Accepts a length command, streams operand reads (rd_en/rd_addr, data one
// cycle later on rd_a/rd_b), accumulates via MLP_mac and offers the result
// on a valid/ready handshake.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake, cmd_len = vector length
//   rd_en/rd_addr            : operand read strobe and index
//   rd_a/rd_b                : signed operands returned one cycle after rd_en
//   res_valid/res_ready      : result handshake, res_data = dot product
//   busy                     : high whenever the FSM is not idle
// Build option: define MLP_DOT_SEQ_RELU_EN to output max(0, acc).
module mlp_dot_seq
  import mlp_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 64,
  parameter int MAX_LEN   = 256,
  localparam int LEN_W    = calc_len_w(MAX_LEN),
  localparam int ADDR_W   = calc_addr_w(MAX_LEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [LEN_W-1:0]            cmd_len,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic signed [A_WIDTH-1:0]   rd_a,
  input  logic signed [B_WIDTH-1:0]   rd_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [ACC_WIDTH-1:0] res_data,
  output logic                        busy
);

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   r_last_addr;
  logic                r_res_valid;
  logic                r_busy;
  logic                r_pipe_vld;
  logic                r_pipe_first;

  logic                        w_handshake;
  logic [LEN_W-1:0]            w_len;
  logic [ADDR_W-1:0]           w_last;
  logic                        w_mac_clr;
  logic                        w_mac_start;
  logic                        w_mac_valid;
  logic signed [ACC_WIDTH-1:0] w_acc;

  assign w_handshake = cmd_valid && r_cmd_ready;
  assign w_len       = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign w_last      = ADDR_W'(w_len - LEN_W'(1));

  // Operand pairs arrive one cycle after their read strobe; the pipe flags
  // mirror rd_en delayed by one cycle. Forced low while reset is asserted.
  assign w_mac_clr   = rst_n && w_handshake;
  assign w_mac_start = rst_n && r_pipe_vld && r_pipe_first;
  assign w_mac_valid = rst_n && r_pipe_vld && !r_pipe_first;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b1;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_last_addr  <= '0;
      r_res_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_pipe_vld   <= 1'b0;
      r_pipe_first <= 1'b0;
    end else begin
      r_pipe_vld   <= r_rd_en;
      r_pipe_first <= r_rd_en && (r_rd_addr == '0);
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_last_addr <= w_last;
            if (w_len != '0) begin
              r_state   <= ST_FETCH;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
            end else begin
              // Empty vector: the accumulator was just cleared, report 0.
              r_state     <= ST_OUT;
              r_res_valid <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (r_rd_addr == r_last_addr) begin
            r_rd_en <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          // Last product lands in the accumulator on this edge.
          r_state     <= ST_OUT;
          r_res_valid <= 1'b1;
        end
        ST_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  MLP_mac #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_mac_clr),
    .i_start(w_mac_start),
    .i_valid(w_mac_valid),
    .i_a    (rd_a),
    .i_b    (rd_b),
    .o_acc  (w_acc)
  );

  assign cmd_ready = r_cmd_ready;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign res_valid = r_res_valid;
  assign busy      = r_busy;

`ifdef MLP_DOT_SEQ_RELU_EN
  assign res_data = w_acc[ACC_WIDTH-1] ? '0 : w_acc;
`else
  assign res_data = w_acc;
`endif

endmodule

// File: tb/tb_mlp_dot_seq.sv
// Directed testbench for mlp_dot_seq (default parameters).
module tb_mlp_dot_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [8:0]         cmd_len;
  logic               rd_en;
  logic [7:0]         rd_addr;
  logic signed [15:0] rd_a;
  logic signed [15:0] rd_b;
  logic               res_valid;
  logic               res_ready;
  logic signed [63:0] res_data;
  logic               busy;

  logic signed [15:0] a_mem [0:255];
  logic signed [15:0] b_mem [0:255];

  int total = 0;
  int bad   = 0;

  mlp_dot_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len  (cmd_len),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Operand memory: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= a_mem[rd_addr];
      rd_b <= b_mem[rd_addr];
    end
  end

  // Drives one command from a negedge and observes it until res_valid.
  // Cycle 0 is the handshake cycle; cycles are sampled at negedges.
  task automatic do_cmd(input int len, output int n_rd, output int first_rd,
                        output int last_rd, output int addr_err, output int vcyc,
                        output logic signed [63:0] data, output bit tmo);
    int cyc;
    int w;
    n_rd = 0; first_rd = -1; last_rd = -1; addr_err = 0; vcyc = -1;
    data = '0; tmo = 1'b0;
    cmd_len   = 9'(len);
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      tmo = 1'b1;
      return;
    end
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) cmd_valid = 1'b0;
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        else if (cyc != last_rd + 1) addr_err++;
        last_rd = cyc;
        if (int'(rd_addr) != n_rd) addr_err++;
        n_rd++;
      end
      if (res_valid) begin
        vcyc = cyc;
        data = res_data;
        $display("txn len=%0d reads=%0d res_cycle=%0d res_data=%0d", len, n_rd, vcyc, data);
        return;
      end
    end
    tmo = 1'b1;
    $display("txn len=%0d no result within budget", len);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    total++; if (rd_addr !== 8'd0) begin bad++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    total++; if (res_data !== 64'sd0) begin bad++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_basic();
    int n, f, l, ae, vc; logic signed [63:0] d; bit t;
    a_mem[0] = 16'sd1; a_mem[1] = 16'sd2; a_mem[2] = 16'sd3;
    b_mem[0] = 16'sd4; b_mem[1] = 16'sd5; b_mem[2] = 16'sd6;
    do_cmd(3, n, f, l, ae, vc, d, t);
    total++; if (t !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b want 0", t); end
    total++; if (f != 1 || l != 3 || n != 3) begin bad++; $display("FAIL basic_rd_window: got first=%0d last=%0d n=%0d want 1 3 3", f, l, n); end
    total++; if (ae != 0) begin bad++; $display("FAIL basic_addr: got errors=%0d want 0", ae); end
    total++; if (vc != 5) begin bad++; $display("FAIL basic_res_cycle: got %0d want 5", vc); end
    total++; if (d !== 64'sd32) begin bad++; $display("FAIL basic_data: got %0d want 32", d); end
    total++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_out_flags: got ready=%b busy=%b want 0 1", cmd_ready, busy); end
    accept();
    total++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_idle: got valid=%b ready=%b busy=%b want 0 1 0", res_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_negative();
    int n, f, l, ae, vc; logic signed [63:0] d; bit t; logic signed [63:0] exp_d;
`ifdef MLP_DOT_SEQ_RELU_EN
    exp_d = 64'sd0;
`else
    exp_d = -64'sd19;
`endif
    a_mem[0] = -16'sd3; a_mem[1] = 16'sd1;
    b_mem[0] = 16'sd7;  b_mem[1] = 16'sd2;
    do_cmd(2, n, f, l, ae, vc, d, t);
    total++; if (vc != 4) begin bad++; $display("FAIL neg_res_cycle: got %0d want 4", vc); end
    total++; if (d !== exp_d) begin bad++; $display("FAIL neg_data: got %0d want %0d", d, exp_d); end
    accept();
  endtask

  task automatic test_zero_len();
    int n, f, l, ae, vc; logic signed [63:0] d; bit t;
    do_cmd(0, n, f, l, ae, vc, d, t);
    total++; if (n != 0) begin bad++; $display("FAIL zero_reads: got %0d want 0", n); end
    total++; if (vc != 1) begin bad++; $display("FAIL zero_res_cycle: got %0d want 1", vc); end
    total++; if (d !== 64'sd0) begin bad++; $display("FAIL zero_data: got %0d want 0", d); end
    accept();
  endtask

  task automatic test_hold();
    int n, f, l, ae, vc; logic signed [63:0] d; bit t;
    a_mem[0] = 16'sd5; a_mem[1] = 16'sd6;
    b_mem[0] = 16'sd3; b_mem[1] = 16'sd4;
    do_cmd(2, n, f, l, ae, vc, d, t);
    total++; if (d !== 64'sd39) begin bad++; $display("FAIL hold_data: got %0d want 39", d); end
    cmd_valid = 1'b1; cmd_len = 9'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || res_data !== 64'sd39 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL hold_cycle%0d: got valid=%b data=%0d ready=%b busy=%b want 1 39 0 1",
                 i, res_valid, res_data, cmd_ready, busy);
      end
    end
    cmd_valid = 1'b0;
    accept();
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL hold_idle: got ready=%b busy=%b valid=%b want 1 0 0", cmd_ready, busy, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n, f, l, ae, vc; logic signed [63:0] d; bit t;
    a_mem[0] = 16'sd7; b_mem[0] = 16'sd9;
    do_cmd(1, n, f, l, ae, vc, d, t);
    total++; if (vc != 3 || d !== 64'sd63) begin bad++; $display("FAIL b2b_first: got cycle=%0d data=%0d want 3 63", vc, d); end
    accept();
    a_mem[0] = -16'sd4; b_mem[0] = -16'sd5;
    do_cmd(1, n, f, l, ae, vc, d, t);
    total++; if (vc != 3 || d !== 64'sd20) begin bad++; $display("FAIL b2b_second: got cycle=%0d data=%0d want 3 20", vc, d); end
    accept();
  endtask

  task automatic test_abort();
    int n, f, l, ae, vc; logic signed [63:0] d; bit t; int seen;
    for (int i = 0; i < 8; i++) begin a_mem[i] = 16'sd1; b_mem[i] = 16'sd1; end
    cmd_valid = 1'b1; cmd_len = 9'd8;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rd_en !== 1'b1 || rd_addr !== 8'd2) begin bad++; $display("FAIL abort_pre: got rd_en=%b addr=%0d want 1 2", rd_en, rd_addr); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (rd_en !== 1'b0 || busy !== 1'b0 || rd_addr !== 8'd0 || res_data !== 64'sd0) begin
      bad++; $display("FAIL abort_reset: got rd_en=%b busy=%b addr=%0d data=%0d want 0 0 0 0", rd_en, busy, rd_addr, res_data);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
    a_mem[0] = -16'sd32768; b_mem[0] = -16'sd32768;
    do_cmd(1, n, f, l, ae, vc, d, t);
    total++; if (d !== 64'sd1073741824) begin bad++; $display("FAIL abort_next: got %0d want 1073741824", d); end
    accept();
  endtask

  task automatic test_max_len();
    int n, f, l, ae, vc; logic signed [63:0] d; bit t;
    for (int i = 0; i < 256; i++) begin a_mem[i] = 16'sd32767; b_mem[i] = 16'sd32767; end
    do_cmd(256, n, f, l, ae, vc, d, t);
    total++; if (n != 256 || f != 1 || l != 256) begin bad++; $display("FAIL max_window: got n=%0d first=%0d last=%0d want 256 1 256", n, f, l); end
    total++; if (ae != 0) begin bad++; $display("FAIL max_addr: got errors=%0d want 0", ae); end
    total++; if (vc != 258) begin bad++; $display("FAIL max_res_cycle: got %0d want 258", vc); end
    total++; if (d !== 64'sd274861129984) begin bad++; $display("FAIL max_data: got %0d want 274861129984", d); end
    accept();
  endtask

  task automatic test_clamp();
    int n, f, l, ae, vc; logic signed [63:0] d; bit t;
    for (int i = 0; i < 256; i++) begin a_mem[i] = 16'sd1; b_mem[i] = 16'(i); end
    do_cmd(300, n, f, l, ae, vc, d, t);
    total++; if (n != 256 || ae != 0) begin bad++; $display("FAIL clamp_reads: got n=%0d errors=%0d want 256 0", n, ae); end
    total++; if (d !== 64'sd32640) begin bad++; $display("FAIL clamp_data: got %0d want 32640", d); end
    accept();
  endtask

  initial begin
    rd_a = '0; rd_b = '0;
    for (int i = 0; i < 256; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
    @(negedge clk);
    test_reset();
    test_basic();
    test_negative();
    test_zero_len();
    test_hold();
    test_back_to_back();
    test_abort();
    test_max_len();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
